// File: rtl/graphic_pkg.sv
// Shared raster timing defaults, frame-size helpers and the stream-to-video FSM encoding.
// No logic of its own; sizes counters and decodes for the video blocks.
// No flow control here.
package graphic_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } vso_state_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters with sync and active-region decode.
// Counters advance once per ce cycle; decodes are combinational from the counters.
// No backpressure: timing never stalls for the pixel source.
module video_timing_gen
    import graphic_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HCNT_W  = cnt_w(H_TOTAL),
    localparam int VCNT_W  = cnt_w(V_TOTAL)
)(
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              ce,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic              hsync,
    output logic              vsync,
    output logic              active
);

    logic [31:0] h_ext;
    logic [31:0] v_ext;

    assign h_ext = 32'(hcnt);
    assign v_ext = 32'(vcnt);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce) begin
            if (h_ext == 32'(H_TOTAL - 1)) begin
                hcnt <= '0;
                vcnt <= (v_ext == 32'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    assign active = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
    assign hsync  = ((h_ext >= 32'(H_ACTIVE + H_FP)) && (h_ext < 32'(H_ACTIVE + H_FP + H_SYNC)))
                    ? HS_POL : ~HS_POL;
    assign vsync  = ((v_ext >= 32'(V_ACTIVE + V_FP)) && (v_ext < 32'(V_ACTIVE + V_FP + V_SYNC)))
                    ? VS_POL : ~VS_POL;

endmodule

// File: rtl/video_stream_out.sv
// Converts a start-of-frame/end-of-line pixel stream into raster video with sticky error flags.
// Video pins are registered: 1 ce cycle from counter value to pin.
// tready_s only in active cycles when locked; non-SOF beats are drained while hunting for frame start.
module video_stream_out
    import graphic_pkg::*;
#(
    parameter int  R_W      = 5,
    parameter int  G_W      = 6,
    parameter int  B_W      = 5,
    localparam int DATA_W   = R_W + G_W + B_W,
    parameter int  H_ACTIVE = DEF_H_ACTIVE,
    parameter int  H_FP     = DEF_H_FP,
    parameter int  H_SYNC   = DEF_H_SYNC,
    parameter int  H_BP     = DEF_H_BP,
    parameter int  V_ACTIVE = DEF_V_ACTIVE,
    parameter int  V_FP     = DEF_V_FP,
    parameter int  V_SYNC   = DEF_V_SYNC,
    parameter int  V_BP     = DEF_V_BP,
    parameter bit  HS_POL   = 1'b1,
    parameter bit  VS_POL   = 1'b1,
    parameter logic [DATA_W-1:0] BLANK_RGB = '0
)(
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              ce,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] tdata_s,
    input  logic              tuser_s,
    input  logic              tlast_s,
    input  logic              tvalid_s,
    output logic              tready_s,
    output logic [R_W-1:0]    video_r,
    output logic [G_W-1:0]    video_g,
    output logic [B_W-1:0]    video_b,
    output logic              hsync,
    output logic              vsync,
    output logic              hblank,
    output logic              vblank,
    output logic              active_video,
    output logic              frame_start,
    output logic              err_underflow,
    output logic              err_sync,
    output logic              locked
);

    localparam int HCNT_W = cnt_w(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VCNT_W = cnt_w(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

    logic [HCNT_W-1:0] hcnt;
    logic [VCNT_W-1:0] vcnt;
    logic              hsync_d;
    logic              vsync_d;
    logic              active_d;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (HS_POL),   .VS_POL (VS_POL)
    ) u_timing (
        .hclk    (hclk),
        .hresetn (hresetn),
        .ce      (ce),
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .hsync   (hsync_d),
        .vsync   (vsync_d),
        .active  (active_d)
    );

    logic origin;
    logic last_col;
    logic stray_sof;

    assign origin    = (hcnt == '0) && (vcnt == '0);
    assign last_col  = (32'(hcnt) == 32'(H_ACTIVE - 1));
    assign stray_sof = tvalid_s & tuser_s & ~origin;

    vso_state_t state;
    vso_state_t state_nxt;
    logic       pix_load;
    logic       lock_beat;
    logic       underflow_set;
    logic       sync_set;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= WAIT_SOF;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_SOF: if (lock_beat) state_nxt = RUN;
            RUN:      if (sync_set)  state_nxt = WAIT_SOF;
        endcase
    end

    // A stray SOF is left on the bus so it can seed the next frame at (0,0).
    always_comb begin
        tready_s      = 1'b0;
        pix_load      = 1'b0;
        lock_beat     = 1'b0;
        underflow_set = 1'b0;
        sync_set      = 1'b0;
        if (hresetn && ce) begin
            unique case (state)
                WAIT_SOF: begin
                    tready_s  = tvalid_s & (~tuser_s | origin);
                    lock_beat = tvalid_s & tuser_s & origin;
                    pix_load  = lock_beat;
                end
                RUN: begin
                    if (active_d) begin
                        tready_s      = ~stray_sof;
                        pix_load      = tvalid_s & ~stray_sof;
                        underflow_set = ~tvalid_s;
                        sync_set      = stray_sof | (pix_load & (tlast_s ^ last_col));
                    end
                end
            endcase
        end
    end

    logic [DATA_W-1:0] rgb_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rgb_q         <= '0;
            hsync         <= ~HS_POL;
            vsync         <= ~VS_POL;
            hblank        <= 1'b0;
            vblank        <= 1'b0;
            active_video  <= 1'b0;
            frame_start   <= 1'b0;
            err_underflow <= 1'b0;
            err_sync      <= 1'b0;
        end else if (ce) begin
            if (!active_d) begin
                rgb_q <= '0;
            end else if (pix_load) begin
                rgb_q <= tdata_s;
            end else begin
                rgb_q <= BLANK_RGB;
            end
            hsync         <= hsync_d;
            vsync         <= vsync_d;
            hblank        <= ~(32'(hcnt) < 32'(H_ACTIVE));
            vblank        <= ~(32'(vcnt) < 32'(V_ACTIVE));
            active_video  <= active_d;
            frame_start   <= origin;
            // A new error in the same cycle as a clear keeps the flag set.
            err_underflow <= underflow_set | (err_underflow & ~err_clr);
            err_sync      <= sync_set | (err_sync & ~err_clr);
        end
    end

    assign video_r = rgb_q[DATA_W-1 -: R_W];
    assign video_g = rgb_q[B_W +: G_W];
    assign video_b = rgb_q[B_W-1:0];
    assign locked  = (state == RUN);

endmodule

// File: tb/tb_video_stream_out.sv
// Self-checking bench for video_stream_out on a tiny 8x6 raster with a queue-fed pixel source.
module tb_video_stream_out;

    localparam int HA = 4, HF = 1, HSY = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FR = HT * VT;
    localparam logic [15:0] BLANK = 16'h0000;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        ce = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] tdata_s = '0;
    logic        tuser_s = 1'b0;
    logic        tlast_s = 1'b0;
    logic        tvalid_s = 1'b0;
    logic        tready_s;
    logic [4:0]  video_r;
    logic [5:0]  video_g;
    logic [4:0]  video_b;
    logic        hsync, vsync, hblank, vblank, active_video, frame_start;
    logic        err_underflow, err_sync, locked;

    video_stream_out #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB)
    ) dut (
        .hclk (hclk), .hresetn (hresetn), .ce (ce), .err_clr (err_clr),
        .tdata_s (tdata_s), .tuser_s (tuser_s), .tlast_s (tlast_s),
        .tvalid_s (tvalid_s), .tready_s (tready_s),
        .video_r (video_r), .video_g (video_g), .video_b (video_b),
        .hsync (hsync), .vsync (vsync), .hblank (hblank), .vblank (vblank),
        .active_video (active_video), .frame_start (frame_start),
        .err_underflow (err_underflow), .err_sync (err_sync), .locked (locked)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [15:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t       q[$];
    int          n_run = 0;
    int          n_fail = 0;
    int          taken = 0;
    int          gap_pos = -1;

    // Reference: raster position and lock/error state tracked at frame level.
    int          m_pos = 0;
    bit          m_run = 0;
    bit          m_eu = 0;
    bit          m_es = 0;
    logic [24:0] e_out = '0;

    function automatic logic [24:0] pins();
        return {video_r, video_g, video_b, hsync, vsync, hblank, vblank,
                active_video, frame_start, locked, err_underflow, err_sync};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_run = 0; m_eu = 0; m_es = 0; e_out = '0; gap_pos = -1;
    endtask

    task automatic push_frame(input bit seq, input int skip);
        for (int i = 0; i < HA * VA; i++) begin
            if (i != skip) q.push_back({seq ? 16'(i + 1) : 16'($urandom), i == 0, (i % HA) == HA - 1});
        end
    endtask

    task automatic step(input bit ce_v, input bit clr_v);
        int h, v, old_pos;
        bit act, tv, tu, tl, erdy, etake, su, ss, run_n, hs;
        logic [15:0] px;
        ce = ce_v;
        err_clr = clr_v;
        if (q.size() > 0 && !(ce_v && m_pos == gap_pos)) begin
            tvalid_s = 1'b1; tdata_s = q[0].d; tuser_s = q[0].u; tlast_s = q[0].l;
        end else begin
            tvalid_s = 1'b0; tdata_s = 16'($urandom); tuser_s = 1'($urandom); tlast_s = 1'($urandom);
        end
        @(negedge hclk);
        h = m_pos % HT;
        v = m_pos / HT;
        act = (h < HA) && (v < VA);
        tv = tvalid_s; tu = tuser_s; tl = tlast_s;
        if (!ce_v)      erdy = 1'b0;
        else if (!m_run) erdy = tv && (!tu || m_pos == 0);
        else            erdy = act && !(tv && tu && m_pos != 0);
        n_run++;
        if (tready_s !== erdy) begin
            n_fail++;
            $display("FAIL tready pos=%0d ce=%0b got=%b want=%b", m_pos, ce_v, tready_s, erdy);
        end
        etake = erdy && tv;
        if (ce_v) begin
            su = m_run && act && !tv;
            ss = m_run && act && tv && ((tu && m_pos != 0) || (etake && (tl != (h == HA - 1))));
            run_n = m_run ? !ss : (tv && tu && m_pos == 0);
            if (!act)                        px = 16'h0;
            else if (etake && (m_run || tu)) px = tdata_s;
            else                             px = BLANK;
            hs = (h >= HA + HF) && (h < HA + HF + HSY);
            m_eu = su | (m_eu & !clr_v);
            m_es = ss | (m_es & !clr_v);
            e_out = {px, hs, (v >= VA + VF) && (v < VA + VF + VSY), h >= HA, v >= VA,
                     act, m_pos == 0, run_n, m_eu, m_es};
            m_run = run_n;
            old_pos = m_pos;
            m_pos = (m_pos + 1) % FR;
            if (old_pos == gap_pos) gap_pos = -1;
        end
        etake = tready_s && tvalid_s;
        @(posedge hclk);
        if (etake) begin
            void'(q.pop_front());
            taken++;
        end
        #1;
        n_run++;
        if (pins() !== e_out) begin
            n_fail++;
            $display("FAIL pins pos=%0d got=%h want=%h", m_pos, pins(), e_out);
        end
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        do begin
            step(1'b1, 1'b0);
            guard++;
        end while (m_pos != target && guard < 4 * FR);
        if (m_pos != target) begin
            n_run++; n_fail++;
            $display("FAIL run_to_timeout got=%0d want=%0d", m_pos, target);
        end
    endtask

    task automatic apply_reset();
        hresetn = 1'b0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        tvalid_s = 1'b1; tuser_s = 1'b0; ce = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        n_run++;
        if (pins() !== 25'h0) begin n_fail++; $display("FAIL reset_pins got=%h want=0", pins()); end
        n_run++;
        if (tready_s !== 1'b0) begin n_fail++; $display("FAIL reset_tready got=%b want=0", tready_s); end
        hresetn = 1'b1;
        model_reset();
    endtask

    task automatic test_continuous();
        logic [15:0] seen[$];
        logic [7:0]  hs_line;
        taken = 0;
        push_frame(1'b1, -1);
        push_frame(1'b1, -1);
        for (int i = 0; i < 2 * FR; i++) begin
            step(1'b1, 1'b0);
            if (i < HT) hs_line[i] = hsync;
            if (i == FR - 1) begin
                n_run++;
                if (taken != HA * VA) begin n_fail++; $display("FAIL beats_per_frame got=%0d want=%0d", taken, HA * VA); end
            end
            if (active_video) seen.push_back({video_r, video_g, video_b});
        end
        n_run++;
        if (hs_line !== 8'b0110_0000) begin n_fail++; $display("FAIL hsync_line got=%b want=01100000", hs_line); end
        for (int i = 0; i < 2 * HA * VA; i++) begin
            n_run++;
            if (i >= seen.size() || seen[i] !== 16'(i % (HA * VA) + 1)) begin
                n_fail++;
                $display("FAIL pixel_order idx=%0d got=%h want=%h", i, (i < seen.size()) ? seen[i] : 16'hxxxx, 16'(i % (HA * VA) + 1));
            end
        end
        n_run++;
        if ({locked, err_underflow, err_sync} !== 3'b100) begin
            n_fail++; $display("FAIL cont_status got=%b want=100", {locked, err_underflow, err_sync});
        end
    endtask

    task automatic test_midframe_start();
        apply_reset();
        run_to(2 * HT + 2);
        for (int i = 0; i < 3; i++) q.push_back({16'($urandom), 1'b0, 1'b0});
        push_frame(1'b0, -1);
        repeat (3) step(1'b1, 1'b0);
        n_run++;
        if (q.size() != HA * VA || locked !== 1'b0) begin
            n_fail++; $display("FAIL midframe_drop got_q=%0d got_lock=%b want_q=%0d want_lock=0", q.size(), locked, HA * VA);
        end
        run_to(0);
        step(1'b1, 1'b0);
        n_run++;
        if (locked !== 1'b1 || frame_start !== 1'b1) begin
            n_fail++; $display("FAIL midframe_lock got=%b%b want=11", locked, frame_start);
        end
        run_to(0);
    endtask

    task automatic test_underflow();
        push_frame(1'b0, 5);
        gap_pos = HT + 1;
        repeat (HT + 2) step(1'b1, 1'b0);
        n_run++;
        if ({video_r, video_g, video_b} !== BLANK || err_underflow !== 1'b1 || locked !== 1'b1 || err_sync !== 1'b0) begin
            n_fail++; $display("FAIL underflow got_rgb=%h uf=%b lk=%b sy=%b want rgb=%h 1 1 0",
                               {video_r, video_g, video_b}, err_underflow, locked, err_sync, BLANK);
        end
        run_to(0);
        push_frame(1'b0, -1);
        step(1'b1, 1'b1);
        n_run++;
        if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL err_clr got=%b want=0", err_underflow); end
        run_to(0);
        push_frame(1'b0, 2);
        gap_pos = 2;
        repeat (2) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        n_run++;
        if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_new got=%b want=1", err_underflow); end
        run_to(0);
    endtask

    task automatic test_stray_sof();
        for (int i = 0; i < 7; i++) q.push_back({16'($urandom), i == 0, (i % HA) == HA - 1});
        push_frame(1'b0, -1);
        step(1'b1, 1'b1);
        repeat (HT + 3) step(1'b1, 1'b0);
        n_run++;
        if (err_sync !== 1'b1 || locked !== 1'b0 || q.size() != HA * VA || q[0].u !== 1'b1) begin
            n_fail++; $display("FAIL stray_sof got sy=%b lk=%b q=%0d want 1 0 %0d", err_sync, locked, q.size(), HA * VA);
        end
        run_to(0);
        step(1'b1, 1'b0);
        n_run++;
        if (locked !== 1'b1 || err_sync !== 1'b1) begin
            n_fail++; $display("FAIL relock got lk=%b sy=%b want 1 1", locked, err_sync);
        end
        run_to(0);
    endtask

    task automatic test_ce_toggle();
        logic [15:0] seen[$];
        push_frame(1'b1, -1);
        for (int i = 0; i < 2 * FR; i++) begin
            step(1'((i % 2) == 0), 1'b0);
            if (active_video) seen.push_back({video_r, video_g, video_b});
        end
        n_run++;
        if (seen.size() != 2 * HA * VA) begin
            n_fail++; $display("FAIL ce_len got=%0d want=%0d", seen.size(), 2 * HA * VA);
        end
        for (int i = 0; i < seen.size() && i < 2 * HA * VA; i++) begin
            n_run++;
            if (seen[i] !== 16'(i / 2 + 1)) begin
                n_fail++; $display("FAIL ce_stretch idx=%0d got=%h want=%h", i, seen[i], 16'(i / 2 + 1));
            end
        end
    endtask

    task automatic test_reset_midframe();
        push_frame(1'b0, -1);
        repeat (HT + 3) step(1'b1, 1'b0);
        tvalid_s = 1'b1;
        tuser_s = 1'b0;
        hresetn = 1'b0;
        #1;
        n_run++;
        if (pins() !== 25'h0 || tready_s !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid got=%h rdy=%b want=0 0", pins(), tready_s);
        end
        @(posedge hclk); #1;
        hresetn = 1'b1;
        model_reset();
        push_frame(1'b0, -1);
        run_to(0);
        n_run++;
        if (locked !== 1'b0 || q.size() != HA * VA) begin
            n_fail++; $display("FAIL reset_wait got lk=%b q=%0d want 0 %0d", locked, q.size(), HA * VA);
        end
        step(1'b1, 1'b0);
        n_run++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL reset_relock got=%b want=1", locked); end
        run_to(0);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_midframe_start();
        test_underflow();
        test_stray_sof();
        test_ce_toggle();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
